// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter with a registered one-hot grant, an encoded owner index
// and a hold limit that preempts a long-running owner when others are waiting.
module decoder_rr_arbiter #(
  parameter  int N_REQ    = 8,
  parameter  int MAX_HOLD = 16,
  localparam int IDX_W    = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);
  localparam logic [7:0]       HOLD_MAX = 8'(MAX_HOLD);

  state_t           state_reg;
  logic [N_REQ-1:0] gnt_reg;
  logic [IDX_W-1:0] gnt_idx_reg;
  logic             gnt_valid_reg;
  logic [IDX_W-1:0] rr_ptr_reg;
  logic [7:0]       hold_cnt_reg;

  logic [IDX_W-1:0] cand [N_REQ];
  logic [IDX_W-1:0] winner_next;
  logic             release_now;
  logic             preempt_now;

  // cand[gi] is the requester examined at priority position gi; index
  // arithmetic wraps naturally because N_REQ is a power of two.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    assign cand[gi] = rr_ptr_reg + IDX_W'(gi);
  end

  always_comb begin
    winner_next = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[cand[i]]) winner_next = cand[i];
    end
  end

  assign release_now = !req[gnt_idx_reg];
  assign preempt_now = (hold_cnt_reg >= HOLD_MAX) && (|(req & ~gnt_reg));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      gnt_reg       <= '0;
      gnt_idx_reg   <= '0;
      gnt_valid_reg <= 1'b0;
      rr_ptr_reg    <= '0;
      hold_cnt_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (en && |req) begin
            state_reg     <= GRANT;
            gnt_idx_reg   <= winner_next;
            gnt_reg       <= ONE_HOT0 << winner_next;
            gnt_valid_reg <= 1'b1;
            hold_cnt_reg  <= 8'd1;
          end
        end
        GRANT: begin
          if (release_now || preempt_now) begin
            // gnt_idx keeps the last owner through the dead cycle
            state_reg     <= IDLE;
            gnt_reg       <= '0;
            gnt_valid_reg <= 1'b0;
            rr_ptr_reg    <= gnt_idx_reg + IDX_W'(1);
          end else if (hold_cnt_reg < HOLD_MAX) begin
            hold_cnt_reg <= hold_cnt_reg + 8'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_reg;
  assign gnt_idx   = gnt_idx_reg;
  assign gnt_valid = gnt_valid_reg;

endmodule

// File: doc/decoder_rr_arbiter.md
Name: decoder_rr_arbiter

Overview:
- Round-robin arbiter that shares one decoded select resource among N_REQ requesters.
- Holds a registered winner index, decodes it to a one-hot grant, and enforces a maximum hold time so no requester can starve the others.
- Sits in front of the 3-to-8 one-hot select path. Its gnt bus drives the per-requester enables, and gnt_idx is the encoded select.

Parameters:
- N_REQ, 8, number of requesters; legal values 2, 4, 8. Index width IDX_W = log2(N_REQ) is a derived localparam.
- MAX_HOLD, 16, maximum grant length in cycles before preemption when another request is pending; legal range 2..255. The hold counter is 8 bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low. Reset is synchronous and active-low, sampled on the rising edge of clk.
- en  input  1  arbitration enable; low blocks new grants but does not end the current grant.
- req  input  N_REQ  request vector; bit i is requester i. Held high for as long as the resource is wanted.
- gnt  output  N_REQ  one-hot grant, registered; all zeros when no grant is active.
- gnt_idx  output  IDX_W  encoded index of the current owner, registered.
- gnt_valid  output  1  high while a grant is active; equals |gnt.

Behaviour:
- Reset values: state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, rr_ptr=0, hold_cnt=0. Reset asserted mid-grant drops gnt on the next edge with no dead-cycle exception.
- Invariant, checked every cycle: gnt == (gnt_valid ? (1 << gnt_idx) : 0).
- State IDLE:
  - If en=1 and req!=0, select the first set bit searching upward from rr_ptr, wrapping modulo N_REQ.
  - Next edge: gnt_idx=winner, gnt=1<<winner, gnt_valid=1, hold_cnt=1, state=GRANT.
  - Latency: req sampled at edge k, gnt visible after edge k+1.
- State GRANT, with owner o=gnt_idx:
  - Release: req[o]=0 at the edge. Next edge gives gnt=0, gnt_valid=0, rr_ptr=(o+1) mod N_REQ, state=IDLE. gnt_idx keeps its last value.
  - Preempt: hold_cnt>=MAX_HOLD and (req & ~gnt)!=0. Same transition as release; rr_ptr=(o+1) mod N_REQ.
  - Otherwise: stay in GRANT. hold_cnt increments and saturates at MAX_HOLD, so a lone requester holds indefinitely.
  - Release and preempt in the same cycle are treated as release; the outcome is identical.
- Every grant ends with exactly one dead cycle (gnt=0) before the next grant. The earliest re-grant is two edges after the release or preempt edge.
- en is ignored in GRANT. With en=0 in IDLE, the block stays IDLE and rr_ptr is unchanged.
- Fairness: with all requesters continuously requesting, grants rotate o, o+1, … mod N_REQ. Each grant lasts exactly MAX_HOLD cycles with gnt high, followed by one dead cycle.
- Wrap-around: when the owner is N_REQ-1, rr_ptr becomes 0.
- A requester that drops req during the dead cycle is not granted; requests are only sampled in IDLE.
- No combinational path from req to any output.

Test Plan:
- Reset and single request: hold rst_n=0 for 3 cycles, then release it. Assert req=8'b0000_0100 at edge 0 -> after edge 1, gnt=8'b0000_0100, gnt_idx=2, gnt_valid=1. Drop req at edge 5 -> gnt=0 after edge 6, rr_ptr=3.
- Rotation and wrap (MAX_HOLD=4): hold req=8'hFF -> grants go 0,1,…,7,0. Each has 4 cycles of gnt high, then 1 dead cycle. The invariant holds every cycle.
- Lone holder: req=8'h20 held for 40 cycles -> gnt=8'h20 throughout, no preemption, hold_cnt saturated. Raise req[1] -> gnt=0 on the next edge, then gnt=8'h02 one edge later.
- Pointer priority: owner 6 releases -> rr_ptr=7. Then req=8'b1000_0001 -> winner is 7; after 7 releases, winner is 0.
- en gating: in IDLE with en=0, req=8'h10 for 10 cycles -> gnt stays 0. Raise en -> gnt=8'h10 one edge later. Drop en during the grant -> grant continues.
- Reset mid-grant: with gnt=8'h08, pulse rst_n=0 for 1 edge -> gnt=0, gnt_idx=0, rr_ptr=0. With req=8'hFF afterwards, the first winner is 0.
